router_pkt_tx: RTL and testbench

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkt_tx.sv | 171 +++++++++++++++++
 tb/tb_router_pkt_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers one packet's payload, then streams header, payload
// bytes and an XOR parity byte to the router, honouring busy backpressure.
module router_pkt_tx (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_addr,
  input  logic [5:0] req_len,
  output logic       req_err,
  input  logic       pay_valid,
  input  logic [7:0] pay_data,
  output logic       pay_ready,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_done
);
  localparam int unsigned AW    = 2;
  localparam int unsigned LW    = 6;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 64;

  typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] fill_q, fill_d;
  logic [LW-1:0] rd_q, rd_d;
  logic [DW-1:0] parity_q, parity_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          gap_q, gap_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] header;
  logic          wr_en;

  assign header    = {len_q, addr_q};
  assign req_ready = (state_q == IDLE);
  assign pay_ready = (state_q == LOAD) && (fill_q < len_q);
  assign wr_en     = pay_valid && pay_ready;

  assign pkt_valid = valid_q;
  assign data_out  = data_q;
  assign req_err   = err_q;
  assign tx_done   = done_q;

  // Output registers are loaded on the edge that enters each state, so
  // data_out/pkt_valid only move on an edge where the current byte transfers.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    fill_d   = fill_q;
    rd_d     = rd_q;
    parity_d = parity_q;
    data_d   = data_q;
    valid_d  = valid_q;
    gap_d    = gap_q;
    err_d    = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_addr == 2'd3) begin
            err_d = 1'b1;
          end else begin
            addr_d   = req_addr;
            len_d    = req_len;
            fill_d   = '0;
            rd_d     = '0;
            parity_d = '0;
            if (req_len == '0) begin
              state_d = HEADER;
              valid_d = 1'b1;
              data_d  = {req_len, req_addr};
            end else begin
              state_d = LOAD;
            end
          end
        end
      end
      LOAD: begin
        if (wr_en) begin
          fill_d = fill_q + 6'd1;
          if (fill_q == len_q - 6'd1) begin
            state_d = HEADER;
            valid_d = 1'b1;
            data_d  = header;
          end
        end
      end
      HEADER: begin
        if (!busy) begin
          parity_d = parity_q ^ header;
          if (len_q == '0) begin
            state_d = PARITY;
            valid_d = 1'b0;
            data_d  = parity_q ^ header;
          end else begin
            state_d = PAYLOAD;
            data_d  = mem_q[0];
          end
        end
      end
      PAYLOAD: begin
        if (!busy) begin
          parity_d = parity_q ^ data_q;
          if (rd_q == len_q - 6'd1) begin
            state_d = PARITY;
            valid_d = 1'b0;
            data_d  = parity_q ^ data_q;
          end else begin
            rd_d   = rd_q + 6'd1;
            data_d = mem_q[rd_q + 6'd1];
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          state_d = GAP;
          done_d  = 1'b1;
          data_d  = '0;
          gap_d   = 1'b0;
        end
      end
      GAP: begin
        gap_d = 1'b1;
        if (gap_q && !busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      fill_q   <= '0;
      rd_q     <= '0;
      parity_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      gap_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      fill_q   <= fill_d;
      rd_q     <= rd_d;
      parity_q <= parity_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      done_q   <= done_d;
      gap_q    <= gap_d;
    end
  end

  // Payload storage needs no reset; stale contents are never read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[fill_q] <= pay_data;
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: directed and random packets compared
// against an expected byte list built from the header/payload/parity rules.
module tb_router_pkt_tx;
  logic       clk = 1'b0;
  logic       resetn;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       req_err;
  logic       pay_valid;
  logic [7:0] pay_data;
  logic       pay_ready;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_done;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] pay_mem [64];

  always #5 clk = ~clk;

  router_pkt_tx dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_err   (req_err),
    .pay_valid (pay_valid),
    .pay_data  (pay_data),
    .pay_ready (pay_ready),
    .busy      (busy),
    .pkt_valid (pkt_valid),
    .data_out  (data_out),
    .tx_done   (tx_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sends one packet; abort_item >= 0 asserts reset while that item is shown.
  task automatic run_packet(input logic [1:0] addr, input int len,
                            input int unsigned gap_pct, input int unsigned busy_pct,
                            input int hold_item, input int hold_cycles,
                            input int abort_item);
    logic [7:0] exp_q[$];
    logic [7:0] par;
    int         wait_n;
    int         shown;
    exp_q = {};
    par   = {6'(len), addr};
    exp_q.push_back(par);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(pay_mem[i]);
      par = par ^ pay_mem[i];
    end
    exp_q.push_back(par);

    wait_n = 0;
    while (req_ready !== 1'b1 && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = 6'(len);
    @(negedge clk);
    chk("req_ready_taken", 32'(req_ready), 32'd0);
    chk("req_err_quiet", 32'(req_err), 32'd0);

    // Keep a stray addr-3 request asserted while loading; it must be ignored.
    req_addr = 2'd3;
    for (int i = 0; i < len; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        pay_valid = 1'b0;
        pay_data  = 8'($urandom);
        @(negedge clk);
        chk("req_err_load", 32'(req_err), 32'd0);
      end
      chk("pay_ready_load", 32'(pay_ready), 32'd1);
      pay_valid = 1'b1;
      pay_data  = pay_mem[i];
      @(negedge clk);
    end
    pay_valid = 1'b0;
    req_valid = 1'b0;
    chk("pay_ready_full", 32'(pay_ready), 32'd0);

    wait_n = 0;
    while (pkt_valid !== 1'b1 && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end

    for (int k = 0; k < exp_q.size(); k++) begin
      shown = 0;
      forever begin
        chk("pkt_valid", 32'(pkt_valid), (k == exp_q.size() - 1) ? 32'd0 : 32'd1);
        chk("data_out", 32'(data_out), 32'(exp_q[k]));
        chk("tx_done_early", 32'(tx_done), 32'd0);
        if (k == abort_item && shown == 1) begin
          resetn = 1'b1;
          busy = 1'b0;
          pay_valid = 1'b0;
          #1;
          chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
          chk("rst_data_out", 32'(data_out), 32'd0);
          chk("rst_tx_done", 32'(tx_done), 32'd0);
          chk("rst_pay_ready", 32'(pay_ready), 32'd0);
          @(negedge clk);
          @(negedge clk);
          resetn = 1'b0;
          @(negedge clk);
          chk("post_rst_ready", 32'(req_ready), 32'd1);
          chk("post_rst_valid", 32'(pkt_valid), 32'd0);
          return;
        end
        pay_valid = 1'(($urandom_range(1)));
        pay_data  = 8'($urandom);
        if (k == hold_item && shown < hold_cycles) busy = 1'b1;
        else if (shown >= 20) busy = 1'b0;
        else busy = ($urandom_range(99) < busy_pct);
        @(negedge clk);
        shown++;
        if (!busy) break;
      end
      if (k == hold_item) chk("hold_len", 32'(shown), 32'(hold_cycles + 1));
    end

    pay_valid = 1'b0;
    chk("tx_done_pulse", 32'(tx_done), 32'd1);
    for (int g = 1; g <= 30; g++) begin
      chk("gap_valid", 32'(pkt_valid), 32'd0);
      chk("gap_data", 32'(data_out), 32'd0);
      chk("gap_req_ready", 32'(req_ready), 32'd0);
      if (g > 1) chk("tx_done_once", 32'(tx_done), 32'd0);
      busy = (g >= 10) ? 1'b0 : ($urandom_range(99) < busy_pct);
      @(negedge clk);
      if (g >= 2 && !busy) break;
    end
    chk("idle_after_gap", 32'(req_ready), 32'd1);
    chk("tx_done_idle", 32'(tx_done), 32'd0);
  endtask

  initial begin
    resetn    = 1'b1;
    req_valid = 1'b0;
    req_addr  = 2'd0;
    req_len   = 6'd0;
    pay_valid = 1'b0;
    pay_data  = 8'd0;
    busy      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_pkt_valid", 32'(pkt_valid), 32'd0);
    chk("reset_data_out", 32'(data_out), 32'd0);
    chk("reset_req_err", 32'(req_err), 32'd0);
    chk("reset_tx_done", 32'(tx_done), 32'd0);
    chk("reset_pay_ready", 32'(pay_ready), 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);

    // addr 1, len 3, no stalls
    pay_mem[0] = 8'h11;
    pay_mem[1] = 8'h22;
    pay_mem[2] = 8'h33;
    run_packet(2'd1, 3, 0, 0, -1, 0, -1);

    // same packet, 0x22 stalled for 3 cycles
    run_packet(2'd1, 3, 0, 0, 2, 3, -1);

    // rejected request
    req_valid = 1'b1;
    req_addr  = 2'd3;
    req_len   = 6'd5;
    @(negedge clk);
    chk("err_pulse", 32'(req_err), 32'd1);
    chk("err_stay_idle", 32'(req_ready), 32'd1);
    chk("err_pay_ready", 32'(pay_ready), 32'd0);
    chk("err_pkt_valid", 32'(pkt_valid), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("err_one_cycle", 32'(req_err), 32'd0);
    chk("err_pay_ready2", 32'(pay_ready), 32'd0);
    chk("err_pkt_valid2", 32'(pkt_valid), 32'd0);

    // zero-length packet
    run_packet(2'd2, 0, 0, 20, -1, 0, -1);

    // maximum length with payload gaps
    for (int i = 0; i < 64; i++) pay_mem[i] = 8'($urandom);
    run_packet(2'd0, 63, 30, 0, -1, 0, -1);

    // reset during payload, then a clean packet
    for (int i = 0; i < 64; i++) pay_mem[i] = 8'($urandom);
    run_packet(2'd1, 10, 0, 20, 4, 0, 4);
    for (int i = 0; i < 64; i++) pay_mem[i] = 8'($urandom);
    run_packet(2'd2, 5, 10, 20, -1, 0, -1);

    // random packets
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 64; i++) pay_mem[i] = 8'($urandom);
      run_packet(2'($urandom_range(2)), int'($urandom_range(20)), 25, 30, -1, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
